// File: rtl/fizzbuzz_tokenizer.sv
// fizzbuzz_tokenizer: classifies fizz/buzz/fizzbuzz flags into a 2-bit token,
// tags it with a wrapping sequence index and buffers it in a FIFO.
// The FIFO drives a valid/ready output stream.
// Tokens arriving while the FIFO is full and not draining are dropped and counted.
module fizzbuzz_tokenizer #(
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_en,
  input  logic                          fizz,
  input  logic                          buzz,
  input  logic                          fizzbuzz,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_kind,
  output logic [$clog2(MAX_CYCLES)-1:0] out_index,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int unsigned IdxW = $clog2(MAX_CYCLES);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [1:0]      kind;
  logic [1:0]      mem_kind [DEPTH];
  logic [IdxW-1:0] mem_idx  [DEPTH];
  logic [IdxW-1:0] idx;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            full;
  logic            push;
  logic            pop;
  logic            accept;
  logic            drop;

  // Priority classification: fizzbuzz beats fizz beats buzz.
  always_comb begin
    kind = 2'd0;
    if (fizzbuzz)  kind = 2'd3;
    else if (fizz) kind = 2'd1;
    else if (buzz) kind = 2'd2;
  end

  // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    full      = (level == LvlW'(DEPTH));
    out_valid = (level != '0);
    push      = in_en;
    pop       = out_valid & out_ready;
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
    out_kind  = out_valid ? mem_kind[rd_ptr] : 2'd0;
    out_index = out_valid ? mem_idx[rd_ptr] : '0;
  end

  // Sequence index advances on every enabled cycle, dropped tokens included.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (in_en) begin
      if (idx == IdxW'(MAX_CYCLES - 1)) idx <= '0;
      else                              idx <= idx + IdxW'(1);
    end
  end

  // Token storage; contents are masked by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_kind[wr_ptr] <= kind;
      mem_idx[wr_ptr]  <= idx;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)    rd_ptr <= rd_ptr + PtrW'(1);
      case ({accept, pop})
        2'b10:   level <= level + LvlW'(1);
        2'b01:   level <= level - LvlW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fizzbuzz_tokenizer.sv
// Directed self-checking bench for fizzbuzz_tokenizer.
module tb_fizzbuzz_tokenizer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_en = 1'b0;
  logic       fizz = 1'b0;
  logic       buzz = 1'b0;
  logic       fizzbuzz = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_kind;
  logic [6:0] out_index;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fizzbuzz_tokenizer #(
    .MAX_CYCLES(100),
    .DEPTH     (8),
    .CNT_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_en    (in_en),
    .fizz     (fizz),
    .buzz     (buzz),
    .fizzbuzz (fizzbuzz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_kind (out_kind),
    .out_index(out_index),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream-correct flags for sequence value i.
  task automatic set_flags(input int i);
    fizz     = (i % 3 == 0);
    buzz     = (i % 5 == 0);
    fizzbuzz = (i % 15 == 0);
  endtask

  function automatic logic [1:0] kind_of(input int i);
    if (i % 15 == 0) return 2'd3;
    if (i % 3 == 0)  return 2'd1;
    if (i % 5 == 0)  return 2'd2;
    return 2'd0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_en = 1'b0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    n_cmp++;
    if (level !== 4'd0) begin
      n_bad++; $display("FAIL reset_level got %0d want 0", level);
    end
    n_cmp++;
    if (out_kind !== 2'd0 || out_index !== 7'd0) begin
      n_bad++; $display("FAIL reset_head got kind %0d idx %0d want 0 0", out_kind, out_index);
    end
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_ovf got ovf %0b cnt %0d want 0 0", overflow, drop_cnt);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    in_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_flags(i);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_kind !== kind_of(i) || out_index !== 7'(i)) begin
        n_bad++;
        $display("FAIL stream[%0d] got v%0b k%0d i%0d want v1 k%0d i%0d",
                 i, out_valid, out_kind, out_index, kind_of(i), i);
      end
    end
    in_en = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_drain got valid %0b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    in_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_flags(i);
      step();
    end
    in_en = 1'b0;
    n_cmp++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL ovf_state got lvl %0d ovf %0b cnt %0d want 8 1 2", level, overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_index !== 7'(k) || out_kind !== kind_of(k)) begin
        n_bad++;
        $display("FAIL ovf_drain[%0d] got v%0b i%0d k%0d want v1 i%0d k%0d",
                 k, out_valid, out_index, out_kind, k, kind_of(k));
      end
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL ovf_after got v%0b ovf %0b cnt %0d want 0 1 2", out_valid, overflow, drop_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_en = 1'b1;
    for (int i = 0; i < 102; i++) begin
      set_flags(i % 100);
      step();
      n_cmp++;
      if (out_index !== 7'(i % 100) || out_kind !== kind_of(i % 100)) begin
        n_bad++;
        $display("FAIL wrap[%0d] got i%0d k%0d want i%0d k%0d",
                 i, out_index, out_kind, i % 100, kind_of(i % 100));
      end
    end
    in_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_flags(i);
      step();
    end
    n_cmp++;
    if (level !== 4'd8) begin
      n_bad++; $display("FAIL b2b_fill got lvl %0d want 8", level);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_flags(8 + k);
      n_cmp++;
      if (out_index !== 7'(k)) begin
        n_bad++; $display("FAIL b2b_pop[%0d] got i%0d want %0d", k, out_index, k);
      end
      step();
      n_cmp++;
      if (level !== 4'd8) begin
        n_bad++; $display("FAIL b2b_lvl[%0d] got %0d want 8", k, level);
      end
    end
    in_en = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0 || out_index !== 7'd5) begin
      n_bad++;
      $display("FAIL b2b_end got cnt %0d ovf %0b head %0d want 0 0 5", drop_cnt, overflow, out_index);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_flags(i + 1);
      step();
    end
    n_cmp++;
    if (level !== 4'd4) begin
      n_bad++; $display("FAIL midrst_fill got lvl %0d want 4", level);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_en = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state got v%0b lvl %0d ovf %0b want 0 0 0", out_valid, level, overflow);
    end
    in_en = 1'b1;
    set_flags(0);
    step();
    in_en = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_index !== 7'd0 || out_kind !== 2'd3 || level !== 4'd1) begin
      n_bad++;
      $display("FAIL midrst_push got v%0b i%0d k%0d lvl %0d want 1 0 3 1",
               out_valid, out_index, out_kind, level);
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_en = (i % 2 == 0);
      step();
    end
    in_en = 1'b0;
    n_cmp++;
    if (level !== 4'd2) begin
      n_bad++; $display("FAIL gap_lvl got %0d want 2", level);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_index !== 7'(k) || out_kind !== 2'd0) begin
        n_bad++;
        $display("FAIL gap_tok[%0d] got v%0b i%0d k%0d want 1 %0d 0", k, out_valid, out_index,
                 out_kind, k);
      end
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL gap_empty got v%0b want 0", out_valid);
    end
    // Index must have held at 2 across the idle cycles.
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    n_cmp++;
    if (out_index !== 7'd2) begin
      n_bad++; $display("FAIL gap_next got i%0d want 2", out_index);
    end
  endtask

  task automatic test_priority();
    do_reset();
    in_en = 1'b1;
    fizz = 1'b1; buzz = 1'b1; fizzbuzz = 1'b0;
    step();
    fizz = 1'b0; buzz = 1'b1;
    step();
    in_en = 1'b0;
    n_cmp++;
    if (out_kind !== 2'd1) begin
      n_bad++; $display("FAIL prio_fizzbuzz_raw got k%0d want 1", out_kind);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_kind !== 2'd2 || out_index !== 7'd1) begin
      n_bad++; $display("FAIL prio_buzz got k%0d i%0d want 2 1", out_kind, out_index);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_enable_gap();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
